alu_share_arb: RTL and testbench
================================

# alu_share_arb

Shares the single ALU datapath between up to NREQ independent requesters (fetch/PC-increment, branch compare, execute stage) via per-requester valid/ready handshakes. It arbitrates round-robin and drives the granted operands and `aluop_sel_t` opcode into the ALU. It returns the registered result, zero flag and owner ID on one response channel. Exactly one operation is in flight at a time.

## Interface
- DWIDTH, 8, operand/result width in bits
- NREQ, 2, number of requesters (2..8)
- IDW, $clog2(NREQ), width of the response owner ID (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  request i presents an operation
- req_ready  out  NREQ  request i accepted this cycle
- req_sel  in  NREQ x aluop_sel_t  opcode per requester
- req_src1  in  NREQ x DWIDTH  first operand per requester
- req_src2  in  NREQ x DWIDTH  second operand per requester
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  IDW  index of the requester owning the response
- rsp_res  out  DWIDTH  registered ALU result
- rsp_zero  out  1  rsp_res == 0
- rsp_err  out  1  accepted opcode was not a legal encoding

## Operation
- Legal opcodes: AND=0, OR=1, ADD=2, SUB=6, SLT=7. Any other value is accepted and flagged: rsp_err=1, rsp_res=0, rsp_zero=1.
- ADD/SUB wrap modulo 2^DWIDTH; SUB = src1 + ~src2 + 1.
- SLT is a signed compare: result is 1 (zero-extended to DWIDTH) when $signed(src1) < $signed(src2), else 0.
- FSM states:
  - IDLE: no response held.
  - RESP: response held, rsp_valid=1.
- FSM transitions:
  - IDLE -> RESP on accept.
  - RESP -> IDLE on rsp_ready with no new accept.
  - RESP -> RESP on rsp_ready with a same-cycle accept.
- can_accept = (state==IDLE) || rsp_ready.
- Grant (combinational):
  - Search starts at ptr+1 mod NREQ and picks the first i with req_valid[i].
  - req_ready[i] = can_accept && grant[i]; at most one bit set.
  - req_ready never depends on req_ready itself. It may depend combinationally on req_valid and rsp_ready.
- On accept of requester g:
  - ALU evaluates req_*[g] combinationally.
  - rsp_res, rsp_zero, rsp_err and rsp_id<=g are registered.
  - ptr<=g.
- Requester rules: once req_valid[i] is high, it and its payload stay stable until req_ready[i]. The consumer holds rsp_ready freely.
- While rsp_valid=1 and rsp_ready=0, all rsp_* outputs are stable.
- Fairness: a continuously valid requester is accepted within NREQ accepts.

## Timing
- Reset values: state=IDLE, rsp_valid=0, rsp_res=0, rsp_zero=0, rsp_err=0, rsp_id=0, ptr=NREQ-1 (requester 0 wins first), req_ready=0 while rst_n=0.
- Latency: accept in cycle N -> rsp_valid=1 with result in cycle N+1.
- Throughput: one op per cycle when rsp_ready is held high. Response in RESP and the next accept share the same cycle.
- No accept when no req_valid bit is set. IDLE stays IDLE; a RESP with rsp_ready goes to IDLE.
- Simultaneous valid requesters: only the granted one sees ready. The others wait with no data loss.
- Pointer wrap: after grant to NREQ-1, search starts at 0.
- Reset mid-operation: the held response is dropped immediately (rsp_valid=0 asynchronously). No response survives reset. Arbitration restarts from requester 0.

## Structure
- typedefs_pkg already holds aluop_sel_t. Add there:
  - localparams for the five legal encodings;
  - function is_legal_aluop(aluop_sel_t).
- Sub-module rr_arb #(NREQ): inputs req, ptr; output one-hot grant. Pure combinational, reusable elsewhere.
- Instantiate the existing ALU module on the muxed operands. This block contains no duplicate arithmetic except the illegal-opcode override.
- Formal checker alongside (bind-style), asserting:
  - onehot0(req_ready);
  - rsp_* stable under backpressure;
  - no response without a prior accept;
  - fairness bound.

## Test plan
- Reset then single request: req0 ADD 8'h7F + 8'h01 -> req_ready[0] same cycle; next cycle rsp_valid=1, rsp_res=8'h80, rsp_zero=0, rsp_id=0.
- Contention, rsp_ready=1, both valid continuously:
  - req0 SUB 5-5, req1 OR 8'hF0|8'h0F.
  - Accepts alternate 0,1,0,1.
  - Responses: res=0 with zero=1, then res=8'hFF with zero=0.
- Backpressure:
  - rsp_ready=0 for 3 cycles after response with req1 valid -> req_ready=0 throughout, rsp_* unchanged.
  - rsp_ready=1 -> req1 accepted same cycle.
- Signed SLT:
  - 8'hFF < 8'h01 -> rsp_res=8'h01.
  - 8'h01 < 8'hFF -> rsp_res=8'h00, rsp_zero=1.
- Illegal opcode sel=3 -> accepted; rsp_err=1, rsp_res=0, rsp_zero=1; next legal AND 8'hAA&8'h0F -> rsp_res=8'h0A, rsp_err=0.
- Reset mid-operation:
  - Assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately.
  - After release with both requesters valid -> requester 0 granted first.

Source files
------------

// File: rtl/alu_share_arb_pkg.sv
// Shared types for the ALU arbiter: opcode encodings, legality check and FSM states.
package alu_share_arb_pkg;

  localparam int unsigned SelW = 3;

  typedef logic [SelW-1:0] aluop_sel_t;

  localparam aluop_sel_t AluAnd = 3'd0;
  localparam aluop_sel_t AluOr  = 3'd1;
  localparam aluop_sel_t AluAdd = 3'd2;
  localparam aluop_sel_t AluSub = 3'd6;
  localparam aluop_sel_t AluSlt = 3'd7;

  typedef enum logic {StIdle, StResp} arb_state_e;

  function automatic logic is_legal_aluop(aluop_sel_t sel);
    return sel inside {AluAnd, AluOr, AluAdd, AluSub, AluSlt};
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; unknown opcodes produce zero.
module alu
  import alu_share_arb_pkg::*;
#(
  parameter int unsigned DWIDTH = 8
) (
  input  logic [SelW-1:0]   sel,
  input  logic [DWIDTH-1:0] src1,
  input  logic [DWIDTH-1:0] src2,
  output logic [DWIDTH-1:0] res
);

  always_comb begin
    res = '0;
    case (aluop_sel_t'(sel))
      AluAnd:  res = src1 & src2;
      AluOr:   res = src1 | src2;
      AluAdd:  res = src1 + src2;
      AluSub:  res = src1 + ~src2 + DWIDTH'(1);
      AluSlt:  res = {{(DWIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb_sva.sv
// Assertion-only observer of the arbiter's handshake and fairness properties.
module alu_share_arb_sva #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned NREQ   = 2,
  parameter int unsigned IDW    = 1
) (
  input logic              clk,
  input logic              rst_n,
  input logic [NREQ-1:0]   req_valid,
  input logic [NREQ-1:0]   req_ready,
  input logic              rsp_valid,
  input logic              rsp_ready,
  input logic [IDW-1:0]    rsp_id,
  input logic [DWIDTH-1:0] rsp_res,
  input logic              rsp_zero,
  input logic              rsp_err
);

  logic                  hold_q, acc_q, zero_q, err_q;
  logic [IDW-1:0]        id_q;
  logic [DWIDTH-1:0]     res_q;
  logic [NREQ-1:0][3:0]  wait_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
      acc_q  <= 1'b0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
      id_q   <= '0;
      res_q  <= '0;
      wait_q <= '0;
    end else begin
      assert ($onehot0(req_ready)) else $error("sva: req_ready not onehot0");
      if (hold_q) begin
        assert (rsp_valid && rsp_id == id_q && rsp_res == res_q && rsp_zero == zero_q &&
                rsp_err == err_q)
          else $error("sva: response changed under backpressure");
      end
      // A fresh response must come from an accept on the previous edge.
      if (rsp_valid && !hold_q) begin
        assert (acc_q) else $error("sva: response without accept");
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        assert (32'(wait_q[i]) < NREQ) else $error("sva: fairness bound exceeded");
      end
      hold_q <= rsp_valid && !rsp_ready;
      acc_q  <= |req_ready;
      id_q   <= rsp_id;
      res_q  <= rsp_res;
      zero_q <= rsp_zero;
      err_q  <= rsp_err;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (req_valid[i] && !req_ready[i]) begin
          if (|req_ready) wait_q[i] <= wait_q[i] + 4'd1;
        end else begin
          wait_q[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester after ptr.
module rr_arb #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant
);

  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = IDW'((int'(ptr) + k) % int'(NREQ));
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU among NREQ requesters with round-robin grant and a single
// registered response slot.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned NREQ   = 2,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*SelW-1:0]     req_sel,
  input  logic [NREQ*DWIDTH-1:0]   req_src1,
  input  logic [NREQ*DWIDTH-1:0]   req_src2,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [DWIDTH-1:0]        rsp_res,
  output logic                     rsp_zero,
  output logic                     rsp_err
);

  arb_state_e        state_q, state_d;
  logic [IDW-1:0]    ptr_q;
  logic [NREQ-1:0]   grant;
  logic              can_accept, accept;
  logic [IDW-1:0]    gidx;
  logic [SelW-1:0]   mux_sel;
  logic [DWIDTH-1:0] mux_src1, mux_src2, alu_res, res_final;
  logic              op_legal;
  logic [IDW-1:0]    rsp_id_q;
  logic [DWIDTH-1:0] rsp_res_q;
  logic              rsp_zero_q, rsp_err_q;

  rr_arb #(
    .NREQ(NREQ)
  ) u_rr_arb (
    .req  (req_valid),
    .ptr  (ptr_q),
    .grant(grant)
  );

  assign can_accept = (state_q == StIdle) || rsp_ready;
  // Gate on rst_n so nothing handshakes while reset is held.
  assign req_ready  = (rst_n && can_accept) ? grant : '0;
  assign accept     = |req_ready;

  always_comb begin
    gidx     = '0;
    mux_sel  = '0;
    mux_src1 = '0;
    mux_src2 = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) begin
        gidx     = IDW'(i);
        mux_sel  = req_sel[i*SelW +: SelW];
        mux_src1 = req_src1[i*DWIDTH +: DWIDTH];
        mux_src2 = req_src2[i*DWIDTH +: DWIDTH];
      end
    end
  end

  alu #(
    .DWIDTH(DWIDTH)
  ) u_alu (
    .sel (mux_sel),
    .src1(mux_src1),
    .src2(mux_src2),
    .res (alu_res)
  );

  assign op_legal  = is_legal_aluop(mux_sel);
  assign res_final = op_legal ? alu_res : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StResp;
      StResp:  if (!accept && rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= IDW'(NREQ - 1);
      rsp_id_q   <= '0;
      rsp_res_q  <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q      <= gidx;
        rsp_id_q   <= gidx;
        rsp_res_q  <= res_final;
        rsp_zero_q <= (res_final == '0);
        rsp_err_q  <= !op_legal;
      end
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;

  alu_share_arb_sva #(
    .DWIDTH(DWIDTH),
    .NREQ  (NREQ),
    .IDW   (IDW)
  ) u_sva (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_res  (rsp_res),
    .rsp_zero (rsp_zero),
    .rsp_err  (rsp_err)
  );

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench: expected responses queued at accept, compared when the DUT presents them.
module tb_alu_share_arb;

  localparam int DW = 8;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*3-1:0] req_sel;
  logic [NR*DW-1:0] req_src1, req_src2;
  logic            rsp_valid, rsp_ready;
  logic [0:0]      rsp_id;
  logic [DW-1:0]   rsp_res;
  logic            rsp_zero, rsp_err;

  typedef struct {
    logic [0:0]    id;
    logic [DW-1:0] res;
    logic          zero;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_share_arb #(
    .DWIDTH(DW),
    .NREQ  (NR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_sel  (req_sel),
    .req_src1 (req_src1),
    .req_src2 (req_src2),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_res  (rsp_res),
    .rsp_zero (rsp_zero),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] sel,
                         input logic [7:0] a, input logic [7:0] b);
    req_valid[i]       = v;
    req_sel[i*3 +: 3]  = sel;
    req_src1[i*8 +: 8] = a;
    req_src2[i*8 +: 8] = b;
  endtask

  function automatic exp_t model(input int i);
    exp_t          e;
    logic [2:0]    sel;
    logic [DW-1:0] a, b;
    sel    = req_sel[i*3 +: 3];
    a      = req_src1[i*8 +: 8];
    b      = req_src2[i*8 +: 8];
    e.id   = 1'(i);
    e.err  = 1'b0;
    case (sel)
      3'd0:    e.res = a & b;
      3'd1:    e.res = a | b;
      3'd2:    e.res = a + b;
      3'd6:    e.res = a - b;
      3'd7:    e.res = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      default: begin e.res = 8'd0; e.err = 1'b1; end
    endcase
    e.zero = (e.res == 8'd0);
    return e;
  endfunction

  // One cycle: check ready/valid at the falling edge, compare the head of the
  // scoreboard against the held response, then enqueue any new accept.
  task automatic tick(input string tag, input logic [1:0] exp_rdy, input logic exp_vld);
    exp_t e;
    @(negedge clk);
    chk({tag, " req_ready"}, 32'(req_ready), 32'(exp_rdy));
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(exp_vld));
    if (rsp_valid) begin
      chk({tag, " sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb[0];
        chk({tag, " rsp_id"},   32'(rsp_id),   32'(e.id));
        chk({tag, " rsp_res"},  32'(rsp_res),  32'(e.res));
        chk({tag, " rsp_zero"}, 32'(rsp_zero), 32'(e.zero));
        chk({tag, " rsp_err"},  32'(rsp_err),  32'(e.err));
        if (rsp_ready) void'(sb.pop_front());
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i]) sb.push_back(model(i));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_sel   = '0;
    req_src1  = '0;
    req_src2  = '0;
    set_req(0, 1'b1, 3'd2, 8'h01, 8'h01);
    set_req(1, 1'b1, 3'd2, 8'h01, 8'h01);

    // Reset values, with requests present to show ready is gated.
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_res",   32'(rsp_res),   32'd0);
    chk("reset rsp_zero",  32'(rsp_zero),  32'd0);
    chk("reset rsp_err",   32'(rsp_err),   32'd0);
    chk("reset rsp_id",    32'(rsp_id),    32'd0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n     = 1'b1;

    // Single request: ADD 7F+01.
    set_req(0, 1'b1, 3'd2, 8'h7F, 8'h01);
    tick("add acc", 2'b01, 1'b0);
    req_valid = '0;
    tick("add rsp", 2'b00, 1'b1);

    // Contention with rsp_ready high; ptr=0 so requester 1 leads.
    set_req(0, 1'b1, 3'd6, 8'h05, 8'h05);
    set_req(1, 1'b1, 3'd1, 8'hF0, 8'h0F);
    tick("cont 1", 2'b10, 1'b0);
    tick("cont 2", 2'b01, 1'b1);
    tick("cont 3", 2'b10, 1'b1);
    tick("cont 4", 2'b01, 1'b1);
    req_valid[0] = 1'b0;
    tick("cont 5", 2'b10, 1'b1);
    req_valid[1] = 1'b0;
    tick("cont 6", 2'b00, 1'b1);

    // Backpressure: response held while requester 1 waits.
    set_req(0, 1'b1, 3'd2, 8'h03, 8'h04);
    tick("bp acc", 2'b01, 1'b0);
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 3'd7, 8'hFF, 8'h01);
    rsp_ready = 1'b0;
    tick("bp hold1", 2'b00, 1'b1);
    tick("bp hold2", 2'b00, 1'b1);
    tick("bp hold3", 2'b00, 1'b1);
    rsp_ready = 1'b1;
    tick("bp release", 2'b10, 1'b1);
    req_valid[1] = 1'b0;
    tick("slt neg", 2'b00, 1'b1);
    set_req(1, 1'b1, 3'd7, 8'h01, 8'hFF);
    tick("slt acc2", 2'b10, 1'b0);
    req_valid[1] = 1'b0;
    tick("slt pos", 2'b00, 1'b1);

    // Illegal opcode, then a legal AND from the same requester.
    set_req(0, 1'b1, 3'd3, 8'h12, 8'h34);
    tick("illegal acc", 2'b01, 1'b0);
    set_req(0, 1'b1, 3'd0, 8'hAA, 8'h0F);
    tick("and acc", 2'b01, 1'b1);
    req_valid[0] = 1'b0;
    tick("and rsp", 2'b00, 1'b1);

    // Reset while a response is held.
    set_req(1, 1'b1, 3'd2, 8'h01, 8'h01);
    rsp_ready = 1'b0;
    tick("mid acc", 2'b10, 1'b0);
    req_valid[1] = 1'b0;
    tick("mid hold", 2'b00, 1'b1);
    rst_n = 1'b0;
    set_req(0, 1'b1, 3'd1, 8'h01, 8'h02);
    set_req(1, 1'b1, 3'd0, 8'h3C, 8'h0F);
    #1;
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    tick("post rst 1", 2'b01, 1'b0);
    tick("post rst 2", 2'b10, 1'b1);
    req_valid[1] = 1'b0;
    tick("post rst 3", 2'b01, 1'b1);
    req_valid[0] = 1'b0;
    tick("post rst 4", 2'b00, 1'b1);
    tick("final idle", 2'b00, 1'b0);
    chk("sb drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
